// File: rtl/nv_ram_rws_fifo_ctrl.sv
// FIFO controller for an external nv_ram_rws-style 2-port RAM.
// The RAM writes synchronously, captures its read address on ram_re, and
// returns M[captured address] combinationally on ram_dout. This block owns
// both RAM ports and presents valid/ready push and pop interfaces.
// Occupancy counters alone decide full/empty; the pointers are never compared.
`timescale 1ns/1ps

module nv_ram_rws_fifo_ctrl #(
  parameter int DEPTH = 512,
  parameter int AW    = 9,
  parameter int DW    = 512
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_cnt,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_pd
);

  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Registered state
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;   // next address to issue to the RAM read port
  logic [AW:0]   r_ram_cnt;  // written entries not yet issued
  logic          r_out_vld;  // RAM's held read address has an unpopped entry

  // Combinational handshakes
  logic [AW:0] w_occ;
  logic        w_push;
  logic        w_pop;
  logic        w_re;

  // The presented entry counts toward occupancy, so a write can never land
  // on the address the RAM is currently holding for the consumer.
  assign w_occ   = r_ram_cnt + {{AW{1'b0}}, r_out_vld};
  assign wr_prdy = (w_occ != FULL_CNT);
  assign w_push  = wr_pvld & wr_prdy;
  assign w_pop   = r_out_vld & rd_prdy;
  // Only move the RAM's held address when the presented word is gone or
  // leaving this cycle; this keeps rd_pd stable under backpressure.
  assign w_re    = (r_ram_cnt != '0) & (~r_out_vld | rd_prdy);

  assign fifo_cnt      = w_occ;
  assign rd_pvld       = r_out_vld;
  assign rd_pd         = ram_dout;
  assign ram_we        = w_push;
  assign ram_wa        = r_wr_ptr;
  assign ram_di        = wr_pd;
  assign ram_re        = w_re;
  assign ram_ra        = r_rd_ptr;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

  // Write pointer advances on every accepted push, wrapping at DEPTH-1.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_wr_ptr <= (r_wr_ptr == LAST_ADDR) ? '0 : r_wr_ptr + PTR_ONE;
    end
  end

  // Read pointer and output-valid flag follow read issue and pop.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_rd_ptr  <= '0;
      r_out_vld <= 1'b0;
    end else if (w_re) begin
      r_rd_ptr  <= (r_rd_ptr == LAST_ADDR) ? '0 : r_rd_ptr + PTR_ONE;
      r_out_vld <= 1'b1;
    end else if (w_pop) begin
      r_out_vld <= 1'b0;
    end
  end

  // Unissued-entry count: +1 per push, -1 per read issue, net 0 when both.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_ram_cnt <= '0;
    end else if (w_push && !w_re) begin
      r_ram_cnt <= r_ram_cnt + CNT_ONE;
    end else if (!w_push && w_re) begin
      r_ram_cnt <= r_ram_cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_nv_ram_rws_fifo_ctrl.sv
// Testbench for nv_ram_rws_fifo_ctrl with a behavioural 2-port RAM attached.
// A queue-based reference model tracks held entries, the presented flag and
// the RAM addresses; every cycle's outputs are compared against it, and each
// scenario task adds its own targeted checks.
`timescale 1ns/1ps

module tb_nv_ram_rws_fifo_ctrl;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int DW    = 512;

  logic          nvdla_core_clk;
  logic          nvdla_core_rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW:0]   fifo_cnt;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_pd;

  int n_checks = 0;
  int n_fail   = 0;

  nv_ram_rws_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .fifo_cnt        (fifo_cnt),
    .ram_we          (ram_we),
    .ram_wa          (ram_wa),
    .ram_di          (ram_di),
    .ram_re          (ram_re),
    .ram_ra          (ram_ra),
    .ram_dout        (ram_dout),
    .pwrbus_ram_pd   (pwrbus_ram_pd),
    .ram_pwrbus_pd   (ram_pwrbus_pd)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Behavioural nv_ram_rws: sync write, read address captured on re.
  // NOTE: the memory array has no reset; contents survive a controller reset.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ram_ra_q;
  always @(posedge nvdla_core_clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_ra_q <= ram_ra;
  end
  assign ram_dout = mem[ram_ra_q];

  // Reference model: every held entry in order; head is presented when m_vld.
  logic [DW-1:0] mq[$];
  logic          m_vld = 1'b0;
  int            m_wa  = 0;
  int            m_ra  = 0;

  // Per-cycle observations left for the scenario tasks.
  logic          obs_we, obs_re, obs_pop;
  logic [AW-1:0] obs_wa, obs_ra;
  logic [AW:0]   obs_cnt;

  task automatic model_reset();
    mq.delete();
    m_vld = 1'b0;
    m_wa  = 0;
    m_ra  = 0;
  endtask

  // One clock cycle: drive inputs at the negedge, compare everything against
  // the model 1ns later, advance the model at the posedge, return at negedge.
  task automatic tick(input logic pv, input logic [DW-1:0] pd, input logic pr);
    logic [31:0] pw;
    logic        e_prdy, e_push, e_pop, e_re;
    int          unissued;
    pw = $urandom;
    wr_pvld = pv; wr_pd = pd; rd_prdy = pr; pwrbus_ram_pd = pw;
    #1;
    unissued = mq.size() - (m_vld ? 1 : 0);
    e_prdy   = (mq.size() != DEPTH);
    e_push   = pv && e_prdy;
    e_pop    = m_vld && pr;
    e_re     = (unissued != 0) && (!m_vld || pr);
    obs_we = ram_we; obs_re = ram_re; obs_pop = rd_pvld & pr;
    obs_wa = ram_wa; obs_ra = ram_ra; obs_cnt = fifo_cnt;

    n_checks++;
    if (wr_prdy !== e_prdy) begin
      n_fail++; $display("FAIL sb_wr_prdy t=%0t got=%0b exp=%0b", $time, wr_prdy, e_prdy);
    end
    n_checks++;
    if (rd_pvld !== m_vld) begin
      n_fail++; $display("FAIL sb_rd_pvld t=%0t got=%0b exp=%0b", $time, rd_pvld, m_vld);
    end
    n_checks++;
    if (fifo_cnt !== (AW+1)'(mq.size())) begin
      n_fail++; $display("FAIL sb_fifo_cnt t=%0t got=%0d exp=%0d", $time, fifo_cnt, mq.size());
    end
    n_checks++;
    if (ram_we !== e_push) begin
      n_fail++; $display("FAIL sb_ram_we t=%0t got=%0b exp=%0b", $time, ram_we, e_push);
    end
    n_checks++;
    if (ram_re !== e_re) begin
      n_fail++; $display("FAIL sb_ram_re t=%0t got=%0b exp=%0b", $time, ram_re, e_re);
    end
    n_checks++;
    if (ram_pwrbus_pd !== pw) begin
      n_fail++; $display("FAIL sb_pwrbus t=%0t got=%0h exp=%0h", $time, ram_pwrbus_pd, pw);
    end
    if (e_push) begin
      n_checks++;
      if (ram_wa !== AW'(m_wa) || ram_di !== pd) begin
        n_fail++; $display("FAIL sb_write t=%0t got_wa=%0d exp_wa=%0d got_di=%0h exp_di=%0h",
                           $time, ram_wa, m_wa, ram_di, pd);
      end
    end
    if (e_re) begin
      n_checks++;
      if (ram_ra !== AW'(m_ra)) begin
        n_fail++; $display("FAIL sb_ram_ra t=%0t got=%0d exp=%0d", $time, ram_ra, m_ra);
      end
    end
    if (m_vld) begin
      n_checks++;
      if (rd_pd !== mq[0]) begin
        n_fail++; $display("FAIL sb_rd_pd t=%0t got=%0h exp=%0h", $time, rd_pd, mq[0]);
      end
    end

    @(posedge nvdla_core_clk);
    if (e_pop) void'(mq.pop_front());
    if (e_push) begin
      mq.push_back(pd);
      m_wa = (m_wa + 1) % DEPTH;
    end
    if (e_re) begin
      m_vld = 1'b1;
      m_ra  = (m_ra + 1) % DEPTH;
    end else if (e_pop) begin
      m_vld = 1'b0;
    end
    @(negedge nvdla_core_clk);
  endtask

  // Pop until empty, with a cycle budget.
  task automatic drain(input string tag);
    int guard = 0;
    while (mq.size() != 0 && guard < DEPTH + 16) begin
      tick(1'b0, '0, 1'b1);
      guard++;
    end
    n_checks++;
    if (fifo_cnt !== '0 || rd_pvld !== 1'b0) begin
      n_fail++; $display("FAIL %s_drain fifo_cnt=%0d rd_pvld=%0b exp 0/0", tag, fifo_cnt, rd_pvld);
    end
  endtask

  task automatic test_reset();
    nvdla_core_rstn = 1'b0;
    wr_pvld = 1'b0; wr_pd = '0; rd_prdy = 1'b1; pwrbus_ram_pd = '0;
    #3;
    n_checks++;
    if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || fifo_cnt !== '0 || ram_we !== 1'b0 || ram_re !== 1'b0) begin
      n_fail++; $display("FAIL reset_state vld=%0b prdy=%0b cnt=%0d we=%0b re=%0b exp 0/1/0/0/0",
                         rd_pvld, wr_prdy, fifo_cnt, ram_we, ram_re);
    end
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_latency();
    tick(1'b1, DW'(32'h1234), 1'b1);
    n_checks++;
    if (obs_we !== 1'b1 || obs_re !== 1'b0) begin
      n_fail++; $display("FAIL lat_push we=%0b re=%0b exp 1/0", obs_we, obs_re);
    end
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (obs_re !== 1'b1 || obs_ra !== '0) begin
      n_fail++; $display("FAIL lat_issue re=%0b ra=%0d exp 1/0", obs_re, obs_ra);
    end
    n_checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== DW'(32'h1234)) begin
      n_fail++; $display("FAIL lat_data vld=%0b pd=%0h exp 1/1234", rd_pvld, rd_pd);
    end
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (fifo_cnt !== '0 || rd_pvld !== 1'b0) begin
      n_fail++; $display("FAIL lat_empty cnt=%0d vld=%0b exp 0/0", fifo_cnt, rd_pvld);
    end
  endtask

  task automatic test_fill_and_full_pop();
    int accepted = 0;
    int popped   = 0;
    int guard    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, DW'(i), 1'b0);
      if (obs_we) accepted++;
    end
    n_checks++;
    if (accepted != DEPTH || wr_prdy !== 1'b0 || fifo_cnt !== (AW+1)'(DEPTH)) begin
      n_fail++; $display("FAIL fill_full accepted=%0d prdy=%0b cnt=%0d exp %0d/0/%0d",
                         accepted, wr_prdy, fifo_cnt, DEPTH, DEPTH);
    end
    // Full with a simultaneous pop: the push is refused this cycle.
    tick(1'b1, DW'(999), 1'b1);
    n_checks++;
    if (obs_we !== 1'b0 || obs_pop !== 1'b1) begin
      n_fail++; $display("FAIL full_pop we=%0b pop=%0b exp 0/1", obs_we, obs_pop);
    end
    n_checks++;
    if (wr_prdy !== 1'b1 || fifo_cnt !== (AW+1)'(DEPTH - 1)) begin
      n_fail++; $display("FAIL full_after_pop prdy=%0b cnt=%0d exp 1/%0d", wr_prdy, fifo_cnt, DEPTH - 1);
    end
    tick(1'b1, DW'(999), 1'b0);
    n_checks++;
    if (obs_we !== 1'b1 || fifo_cnt !== (AW+1)'(DEPTH)) begin
      n_fail++; $display("FAIL full_refill we=%0b cnt=%0d exp 1/%0d", obs_we, fifo_cnt, DEPTH);
    end
    // Drain: expect 1..511 then 999 (word 0 left in the full-pop cycle).
    popped = 1;
    while (mq.size() != 0 && guard < DEPTH + 16) begin
      logic [DW-1:0] exp_pd;
      exp_pd = (popped < DEPTH) ? DW'(popped) : DW'(999);
      if (rd_pvld === 1'b1) begin
        n_checks++;
        if (rd_pd !== exp_pd) begin
          n_fail++; $display("FAIL fill_order idx=%0d got=%0h exp=%0h", popped, rd_pd, exp_pd);
        end
      end
      tick(1'b0, '0, 1'b1);
      if (obs_pop) popped++;
      guard++;
    end
    n_checks++;
    if (popped != DEPTH + 1) begin
      n_fail++; $display("FAIL fill_pop_count got=%0d exp=%0d", popped, DEPTH + 1);
    end
    drain("fill");
  endtask

  task automatic test_backpressure();
    logic          hold;
    logic [DW-1:0] hold_pd;
    for (int i = 0; i < 3; i++) tick(1'b1, {16{$urandom}}, 1'b0);
    n_checks++;
    if (fifo_cnt !== (AW+1)'(3)) begin
      n_fail++; $display("FAIL bp_prefill cnt=%0d exp=3", fifo_cnt);
    end
    hold = 1'b0;
    hold_pd = '0;
    for (int i = 0; i < 300; i++) begin
      logic pv, pr, stall;
      if (hold) begin
        n_checks++;
        if (rd_pvld !== 1'b1 || rd_pd !== hold_pd) begin
          n_fail++; $display("FAIL bp_stable cyc=%0d vld=%0b got=%0h exp=%0h", i, rd_pvld, rd_pd, hold_pd);
        end
      end
      pv = (mq.size() < 3) && ($urandom_range(0, 1) == 1);
      pr = ($urandom_range(0, 1) == 1);
      stall = m_vld && !pr;
      if (stall) hold_pd = mq[0];
      tick(pv, {16{$urandom}}, pr);
      if (stall) begin
        n_checks++;
        if (obs_re !== 1'b0) begin
          n_fail++; $display("FAIL bp_no_issue cyc=%0d ram_re=%0b exp=0", i, obs_re);
        end
      end
      hold = stall;
    end
    drain("bp");
  endtask

  task automatic test_stream();
    int pops = 0, wa_wraps = 0, ra_wraps = 0, max_cnt = 0;
    logic [AW-1:0] prev_wa, prev_ra;
    logic          seen_wa = 1'b0, seen_ra = 1'b0;
    prev_wa = '0; prev_ra = '0;
    for (int i = 0; i < 1200; i++) begin
      tick(1'b1, DW'(i + 32'h10000), 1'b1);
      if (int'(obs_cnt) > max_cnt) max_cnt = int'(obs_cnt);
      if (obs_we) begin
        if (seen_wa && prev_wa == AW'(DEPTH - 1) && obs_wa == '0) wa_wraps++;
        prev_wa = obs_wa; seen_wa = 1'b1;
      end
      if (obs_re) begin
        if (seen_ra && prev_ra == AW'(DEPTH - 1) && obs_ra == '0) ra_wraps++;
        prev_ra = obs_ra; seen_ra = 1'b1;
      end
      if (obs_pop) pops++;
      if (i >= 2) begin
        n_checks++;
        if (obs_pop !== 1'b1 || obs_we !== 1'b1) begin
          n_fail++; $display("FAIL stream_rate cyc=%0d pop=%0b push=%0b exp 1/1", i, obs_pop, obs_we);
        end
      end
    end
    n_checks++;
    if (pops != 1198 || max_cnt > 2) begin
      n_fail++; $display("FAIL stream_totals pops=%0d max_cnt=%0d exp 1198/<=2", pops, max_cnt);
    end
    n_checks++;
    if (wa_wraps < 2 || ra_wraps < 2) begin
      n_fail++; $display("FAIL stream_wrap wa_wraps=%0d ra_wraps=%0d exp >=2", wa_wraps, ra_wraps);
    end
    drain("stream");
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      logic pv, pr;
      // Alternate phases that favour filling and favour draining.
      if ((i / 500) % 2 == 0) begin
        pv = ($urandom_range(0, 9) < 8);
        pr = ($urandom_range(0, 9) < 3);
      end else begin
        pv = ($urandom_range(0, 9) < 3);
        pr = ($urandom_range(0, 9) < 8);
      end
      tick(pv, {16{$urandom}}, pr);
    end
    drain("random");
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) tick(1'b1, {16{$urandom}}, 1'b0);
    n_checks++;
    if (fifo_cnt !== (AW+1)'(5)) begin
      n_fail++; $display("FAIL rst_prefill cnt=%0d exp=5", fifo_cnt);
    end
    #2;
    wr_pvld = 1'b0; rd_prdy = 1'b0;
    nvdla_core_rstn = 1'b0;
    #1;
    n_checks++;
    if (rd_pvld !== 1'b0 || wr_prdy !== 1'b1 || fifo_cnt !== '0) begin
      n_fail++; $display("FAIL rst_async vld=%0b prdy=%0b cnt=%0d exp 0/1/0", rd_pvld, wr_prdy, fifo_cnt);
    end
    model_reset();
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    tick(1'b1, DW'(8'hA5), 1'b1);
    n_checks++;
    if (obs_we !== 1'b1 || obs_wa !== '0) begin
      n_fail++; $display("FAIL rst_first_wa we=%0b wa=%0d exp 1/0", obs_we, obs_wa);
    end
    tick(1'b0, '0, 1'b1);
    n_checks++;
    if (rd_pvld !== 1'b1 || rd_pd !== DW'(8'hA5)) begin
      n_fail++; $display("FAIL rst_first_pd vld=%0b pd=%0h exp 1/a5", rd_pvld, rd_pd);
    end
    drain("rst");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill_and_full_pop();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nv_ram_rws_fifo_ctrl.md
Name: nv_ram_rws_fifo_ctrl

Overview:
- FIFO controller that owns both ports of an external nv_ram_rws-style 2-port RAM (default 512x512).
- The RAM has sync write, a read address registered on `re`, and `dout` = M[registered ra] combinationally.
- Presents valid/ready push and pop interfaces to the datapath and drives the RAM's we/wa/di and re/ra.
- Sits between a producer and a consumer in a core-clock pipeline. The RAM instance lives outside, so the same controller serves any RAM depth/width.

Parameters:
- DEPTH, 512, number of RAM entries; power of two ≥ 2
- AW, 9, RAM address width; log2(DEPTH)
- DW, 512, data width

Ports:
- nvdla_core_clk  input  1  sole clock
- nvdla_core_rstn  input  1  asynchronous, active-low reset
- wr_pvld  input  1  push valid
- wr_prdy  output  1  push ready
- wr_pd  input  DW  push data
- rd_pvld  output  1  pop valid
- rd_prdy  input  1  pop ready
- rd_pd  output  DW  pop data
- fifo_cnt  output  AW+1  entries held, including the one presented on rd_pd
- ram_we  output  1  RAM write enable
- ram_wa  output  AW  RAM write address
- ram_di  output  DW  RAM write data
- ram_re  output  1  RAM read-address capture enable
- ram_ra  output  AW  RAM read address
- ram_dout  input  DW  RAM read data
- pwrbus_ram_pd  input  32  power bus; forwarded unchanged
- ram_pwrbus_pd  output  32  to RAM pwrbus_ram_pd

Behaviour:
- State registers:
  - wr_ptr[AW-1:0]
  - rd_ptr[AW-1:0], the next address to issue
  - ram_cnt[AW:0], written entries not yet issued
  - out_vld, meaning the RAM's held read address contains an unpopped entry
- Reset (async on rstn low, all registers immediately):
  - wr_ptr=0, rd_ptr=0, ram_cnt=0, out_vld=0
  - Therefore rd_pvld=0, fifo_cnt=0, wr_prdy=1, ram_we=0, ram_re=0
- RAM contents are not cleared. Reset mid-operation discards all entries; the first push after release lands at address 0.
- Push:
  - push = wr_pvld & wr_prdy
  - ram_we = push, ram_wa = wr_ptr, ram_di = wr_pd, all combinational
  - On the clock edge: wr_ptr+1, wrapping DEPTH-1→0
- Occupancy and ready:
  - occ = ram_cnt + out_vld = fifo_cnt
  - wr_prdy = (occ != DEPTH), derived from registered state only, with no combinational path from rd_prdy
- Pop:
  - rd_pvld = out_vld; rd_pd = ram_dout (combinational passthrough)
  - pop = out_vld & rd_prdy
- Read issue:
  - ram_re = (ram_cnt != 0) & (!out_vld | rd_prdy); ram_ra = rd_ptr
  - On ram_re: rd_ptr+1 (wrapping), out_vld<=1
  - Otherwise, if pop: out_vld<=0
- ram_cnt next = ram_cnt + push - ram_re. Simultaneous push and re is allowed; the net change is 0.
- Data stability: ram_re is never asserted while out_vld & !rd_prdy. The RAM's held address therefore does not change, and rd_pd stays stable under backpressure.
- Overwrite protection: the presented entry counts in occ, so a write can never target the address held by the RAM while it is unpopped.
- Latency:
  - Push accepted at edge N; ram_cnt becomes nonzero after N; ram_re asserts in cycle N+1; rd_pvld=1 in cycle N+2.
  - Empty-FIFO push-to-pop latency is 2 cycles.
- Throughput: one push and one pop per cycle sustained, with no bubbles once out_vld=1 and ram_cnt>0.
- Full (occ=DEPTH): wr_prdy=0. A pop in that cycle does not raise wr_prdy until the next cycle.
- Empty (occ=0): rd_pvld=0, ram_re=0. rd_pd is don't-care while rd_pvld=0.
- Pointers never compare for full/empty; the counters alone decide.
- pwrbus_ram_pd → ram_pwrbus_pd is a pure wire.

Test Plan:
- Reset: assert rstn=0 mid-stream with 5 entries held → immediately rd_pvld=0, wr_prdy=1, fifo_cnt=0. After release, push 0xA5 → ram_wa=0, rd_pd=0xA5 two cycles later.
- Latency: push one word 0x1234 at cycle 10 with rd_prdy=1 → ram_re at cycle 11 with ram_ra=0, rd_pvld=1 in cycle 12, rd_pd=0x1234, fifo_cnt back to 0 at cycle 13.
- Fill: push 512 incrementing words with rd_prdy=0 → wr_prdy drops after the 512th accept, fifo_cnt=512. Then pop all → data 0..511 in order, with wr_prdy=1 the cycle after the first pop.
- Backpressure: 3 entries held; toggle rd_prdy randomly → rd_pd constant whenever rd_pvld & !rd_prdy, and ram_re=0 during those cycles.
- Streaming with wrap: continuous push and pop of 1200 words with rd_prdy=1 → one word per cycle after a 2-cycle fill, in order. ram_wa and ram_ra wrap 511→0 twice; fifo_cnt never exceeds 2.
- Full plus simultaneous pop: at occ=512, rd_prdy=1 and wr_pvld=1 → no push in that cycle, one pop. Next cycle push accepted, and fifo_cnt returns to 512.
